// File: rtl/spi_shift_engine_pkg.sv
// Shared definitions for the SPI shift engine and the SPI controllers built
// around it.
//   state_t    : engine state encoding (ST_IDLE = 1'b0, ST_XFER = 1'b1)
//   WIDTH_MIN/WIDTH_MAX and width_ok() : legal word-length range check
package spi_shift_engine_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Host/strobe-side bundle of the SPI shift engine.
//   master : host word interface plus SPI clock/strobe generator (drives
//            load, strobes, abort and serial input)
//   slave  : the shift engine (drives ready, serial output, status, rx word)
interface spi_shift_engine_if #(
   parameter int WIDTH = 8
);
   logic             LOAD_VALID;
   logic             LOAD_READY;
   logic [WIDTH-1:0] P_DATA_IN;
   logic             MSB_FIRST;
   logic             SAMPLE_EN;
   logic             SHIFT_EN;
   logic             ABORT;
   logic             S_DATA_IN;
   logic             S_DATA_OUT;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] P_DATA_OUT;

   modport master (
      output LOAD_VALID, P_DATA_IN, MSB_FIRST, SAMPLE_EN, SHIFT_EN, ABORT, S_DATA_IN,
      input  LOAD_READY, S_DATA_OUT, BUSY, DONE, P_DATA_OUT
   );

   modport slave (
      input  LOAD_VALID, P_DATA_IN, MSB_FIRST, SAMPLE_EN, SHIFT_EN, ABORT, S_DATA_IN,
      output LOAD_READY, S_DATA_OUT, BUSY, DONE, P_DATA_OUT
   );
endinterface

// File: rtl/spi_bit_counter.sv
// Bit counter for the SPI shift engine.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous return to zero (priority over en)
//   en       : count one shifted bit
//   tc       : high while the count equals WIDTH-1 (next shift is the last)
module spi_bit_counter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic tc
);
   logic [CNT_W-1:0] cnt;

   // Holding at terminal count keeps the counter inside 0..WIDTH-1 even if
   // the surrounding FSM were ever to miss its clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              cnt <= '0;
      else if (clear)       cnt <= '0;
      else if (en && !tc)   cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shift engine: parallel load of a WIDTH-bit word, serial
// shift-out while receiving, parallel presentation of the received word.
//   CLK, CLR : clock, asynchronous active-high reset
//   bus      : spi_shift_engine_if.slave (load handshake, sample/shift
//              strobes, abort, serial in/out, BUSY/DONE, received word)
module spi_shift_engine
   import spi_shift_engine_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                CLK,
   input  logic                CLR,
   spi_shift_engine_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH);

   if (!width_ok(WIDTH)) begin : g_width_chk
      $error("spi_shift_engine: WIDTH must be in 2..32");
   end

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] p_data_out;
   logic             order;
   logic             samp;
   logic             done;
   logic             in_bit;
   logic             last_bit;
   logic             load_acc;
   logic             shift_ok;
   logic             cnt_clear;

   // A sample strobe coincident with the shift strobe feeds the shifter
   // directly instead of waiting for the sample register.
   assign in_bit  = bus.SAMPLE_EN ? bus.S_DATA_IN : samp;
   assign shifted = order ? {shreg[WIDTH-2:0], in_bit}
                          : {in_bit, shreg[WIDTH-1:1]};

   assign load_acc  = (state == ST_IDLE) && bus.LOAD_VALID;
   // Abort suppresses the shift entirely, including a final one.
   assign shift_ok  = (state == ST_XFER) && bus.SHIFT_EN && !bus.ABORT;
   assign cnt_clear = load_acc || ((state == ST_XFER) && bus.ABORT) ||
                      (shift_ok && last_bit);

   spi_bit_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_bit_counter (
      .clk   (CLK),
      .rst   (CLR),
      .clear (cnt_clear),
      .en    (shift_ok),
      .tc    (last_bit)
   );

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         samp       <= 1'b0;
         order      <= 1'b1;
         p_data_out <= '0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.LOAD_VALID) begin
                  shreg <= bus.P_DATA_IN;
                  order <= bus.MSB_FIRST;
                  samp  <= 1'b0;
                  state <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (bus.SAMPLE_EN) samp <= bus.S_DATA_IN;
               if (bus.ABORT) begin
                  state <= ST_IDLE;
               end else if (bus.SHIFT_EN) begin
                  shreg <= shifted;
                  if (last_bit) begin
                     p_data_out <= shifted;
                     done       <= 1'b1;
                     state      <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.S_DATA_OUT = order ? shreg[WIDTH-1] : shreg[0];
   assign bus.BUSY       = (state == ST_XFER);
   assign bus.LOAD_READY = (state == ST_IDLE);
   assign bus.DONE       = done;
   assign bus.P_DATA_OUT = p_data_out;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine at WIDTH=8 and WIDTH=16.
module tb_spi_shift_engine;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   spi_shift_engine_if #(.WIDTH(8))  b8 ();
   spi_shift_engine_if #(.WIDTH(16)) b16 ();

   spi_shift_engine #(.WIDTH(8)) dut8 (
      .CLK (clk),
      .CLR (rst),
      .bus (b8)
   );

   spi_shift_engine #(.WIDTH(16)) dut16 (
      .CLK (clk),
      .CLR (rst),
      .bus (b16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One non-bypass bit: sample strobe, then shift strobe a cycle later with
   // S_DATA_IN flipped so only the sampled value can reach the shifter.
   task automatic strobe8(input logic b);
      b8.S_DATA_IN = b;
      b8.SAMPLE_EN = 1'b1;
      tick();
      b8.SAMPLE_EN = 1'b0;
      b8.S_DATA_IN = ~b;
      b8.SHIFT_EN  = 1'b1;
      tick();
      b8.SHIFT_EN  = 1'b0;
   endtask

   task automatic xfer8(input string tag, input logic [7:0] word, input logic msb,
                        input logic [7:0] rx, input logic loop, input logic bypass,
                        input logic [7:0] exp);
      logic exp_tx;
      b8.LOAD_VALID = 1'b1;
      b8.P_DATA_IN  = word;
      b8.MSB_FIRST  = msb;
      tick();
      b8.LOAD_VALID = 1'b0;
      b8.P_DATA_IN  = 8'h00;
      b8.MSB_FIRST  = ~msb;
      chk({tag, ".busy"}, 32'(b8.BUSY), 1);
      chk({tag, ".ready"}, 32'(b8.LOAD_READY), 0);
      for (int i = 0; i < 8; i++) begin
         exp_tx = msb ? word[7-i] : word[i];
         chk($sformatf("%s.tx%0d", tag, i), 32'(b8.S_DATA_OUT), 32'(exp_tx));
         if (bypass) begin
            b8.S_DATA_IN = loop ? exp_tx : rx[i];
            b8.SAMPLE_EN = 1'b1;
            b8.SHIFT_EN  = 1'b1;
            tick();
            b8.SAMPLE_EN = 1'b0;
            b8.SHIFT_EN  = 1'b0;
         end else begin
            strobe8(loop ? exp_tx : rx[i]);
         end
         if (i < 7) chk($sformatf("%s.nodone%0d", tag, i), 32'(b8.DONE), 0);
      end
      chk({tag, ".done"}, 32'(b8.DONE), 1);
      chk({tag, ".pout"}, 32'(b8.P_DATA_OUT), 32'(exp));
      chk({tag, ".busy_end"}, 32'(b8.BUSY), 0);
      chk({tag, ".ready_end"}, 32'(b8.LOAD_READY), 1);
      tick();
      chk({tag, ".done_pulse"}, 32'(b8.DONE), 0);
      chk({tag, ".pout_hold"}, 32'(b8.P_DATA_OUT), 32'(exp));
   endtask

   initial begin
      logic [15:0] w16;
      logic        exp_tx;
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      {b8.LOAD_VALID, b8.MSB_FIRST, b8.SAMPLE_EN, b8.SHIFT_EN, b8.ABORT, b8.S_DATA_IN} = '0;
      b8.P_DATA_IN = '0;
      {b16.LOAD_VALID, b16.MSB_FIRST, b16.SAMPLE_EN, b16.SHIFT_EN, b16.ABORT, b16.S_DATA_IN} = '0;
      b16.P_DATA_IN = '0;

      #12;
      chk("rst.sout", 32'(b8.S_DATA_OUT), 0);
      chk("rst.pout", 32'(b8.P_DATA_OUT), 0);
      chk("rst.done", 32'(b8.DONE), 0);
      chk("rst.busy", 32'(b8.BUSY), 0);
      chk("rst.ready", 32'(b8.LOAD_READY), 1);
      rst = 1'b0;
      tick();

      xfer8("msb_a5", 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 8'hA5);
      xfer8("lsb_01", 8'h00, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01);
      xfer8("msb_80", 8'h80, 1'b1, 8'h01, 1'b0, 1'b0, 8'h80);
      xfer8("bypass", 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF);

      // Abort after 3 shifts with LOAD_VALID held through the transfer.
      b8.LOAD_VALID = 1'b1;
      b8.P_DATA_IN  = 8'h3C;
      b8.MSB_FIRST  = 1'b1;
      tick();
      b8.LOAD_VALID = 1'b0;
      for (int i = 0; i < 3; i++) strobe8(1'b0);
      b8.LOAD_VALID = 1'b1;
      b8.P_DATA_IN  = 8'h81;
      tick();
      chk("abort.ready_held", 32'(b8.LOAD_READY), 0);
      chk("abort.busy_held", 32'(b8.BUSY), 1);
      b8.ABORT = 1'b1;
      tick();
      b8.ABORT = 1'b0;
      chk("abort.busy", 32'(b8.BUSY), 0);
      chk("abort.done", 32'(b8.DONE), 0);
      chk("abort.ready", 32'(b8.LOAD_READY), 1);
      chk("abort.pout", 32'(b8.P_DATA_OUT), 32'hFF);
      tick();
      b8.LOAD_VALID = 1'b0;
      chk("abort.reload_busy", 32'(b8.BUSY), 1);
      chk("abort.reload_tx", 32'(b8.S_DATA_OUT), 1);

      // Abort coinciding with the final shift: abort wins.
      for (int i = 0; i < 7; i++) strobe8(1'b1);
      b8.SHIFT_EN = 1'b1;
      b8.ABORT    = 1'b1;
      tick();
      b8.SHIFT_EN = 1'b0;
      b8.ABORT    = 1'b0;
      chk("abort_last.done", 32'(b8.DONE), 0);
      chk("abort_last.busy", 32'(b8.BUSY), 0);
      chk("abort_last.pout", 32'(b8.P_DATA_OUT), 32'hFF);
      tick();
      chk("abort_last.done2", 32'(b8.DONE), 0);

      // Asynchronous reset between edges in the middle of a transfer.
      b8.LOAD_VALID = 1'b1;
      b8.P_DATA_IN  = 8'hC3;
      tick();
      b8.LOAD_VALID = 1'b0;
      strobe8(1'b1);
      chk("clr.pre_tx", 32'(b8.S_DATA_OUT), 1);
      rst = 1'b1;
      #1;
      chk("clr.busy", 32'(b8.BUSY), 0);
      chk("clr.ready", 32'(b8.LOAD_READY), 1);
      chk("clr.pout", 32'(b8.P_DATA_OUT), 0);
      chk("clr.done", 32'(b8.DONE), 0);
      chk("clr.sout", 32'(b8.S_DATA_OUT), 0);
      rst = 1'b0;
      xfer8("after_clr", 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 8'h5A);

      // WIDTH=16 loopback, load offered on the final-shift cycle.
      w16 = 16'hBEEF;
      b16.LOAD_VALID = 1'b1;
      b16.P_DATA_IN  = w16;
      b16.MSB_FIRST  = 1'b1;
      tick();
      b16.LOAD_VALID = 1'b0;
      chk("w16.busy", 32'(b16.BUSY), 1);
      for (int i = 0; i < 16; i++) begin
         exp_tx = w16[15-i];
         chk($sformatf("w16.tx%0d", i), 32'(b16.S_DATA_OUT), 32'(exp_tx));
         b16.S_DATA_IN = exp_tx;
         b16.SAMPLE_EN = 1'b1;
         tick();
         b16.SAMPLE_EN = 1'b0;
         b16.SHIFT_EN  = 1'b1;
         if (i == 15) begin
            b16.LOAD_VALID = 1'b1;
            b16.P_DATA_IN  = 16'h9234;
         end
         tick();
         b16.SHIFT_EN = 1'b0;
         if (i < 15) chk($sformatf("w16.nodone%0d", i), 32'(b16.DONE), 0);
      end
      chk("w16.done", 32'(b16.DONE), 1);
      chk("w16.pout", 32'(b16.P_DATA_OUT), 32'hBEEF);
      chk("w16.ready", 32'(b16.LOAD_READY), 1);
      chk("w16.busy_end", 32'(b16.BUSY), 0);
      tick();
      b16.LOAD_VALID = 1'b0;
      chk("w16.b2b_busy", 32'(b16.BUSY), 1);
      chk("w16.b2b_done", 32'(b16.DONE), 0);
      chk("w16.b2b_tx", 32'(b16.S_DATA_OUT), 1);
      b16.ABORT = 1'b1;
      tick();
      b16.ABORT = 1'b0;
      chk("w16.abort_busy", 32'(b16.BUSY), 0);
      chk("w16.abort_pout", 32'(b16.P_DATA_OUT), 32'hBEEF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
